// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - systolic input skew generator driving the PE_MAC activation rows
//
// Purpose: accepts one ROWS-element column vector per cycle (valid/ready) and
// drives PE row r with element r delayed by r cycles, together with skewed
// valid/first/last tile markers. After the last vector of a tile the feeder
// stalls for ROWS-1 cycles so consecutive tiles never overlap on any row.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-high
//   in_m      in   ROWS*WIDTH input vector, element r at [r*WIDTH +: WIDTH]
//   in_valid  in   in_m / in_last valid
//   in_last   in   final vector of a tile
//   in_ready  out  vector can be accepted this cycle (state only)
//   o_m       out  ROWS*WIDTH skewed operands, row r at [r*WIDTH +: WIDTH]
//   o_valid   out  per-row operand valid
//   o_first   out  per-row first-of-tile marker
//   o_last    out  per-row last-of-tile marker
//   o_done    out  one-cycle pulse when the tile's last element reaches row ROWS-1
//   o_busy    out  high while streaming or flushing
module pe_feeder #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROWS*WIDTH-1:0] in_m,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ROWS*WIDTH-1:0] o_m,
  output logic [ROWS-1:0]       o_valid,
  output logic [ROWS-1:0]       o_first,
  output logic [ROWS-1:0]       o_last,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t          state_q;
  logic            ready_q;
  logic [CW-1:0]   cnt_q;
  logic            done_d;
  logic            done_q;

  logic accept;
  logic acc_first;
  logic acc_last;

  assign accept    = in_valid && ready_q;
  // Any accept taken while IDLE opens a new tile.
  assign acc_first = accept && (state_q == IDLE);
  assign acc_last  = accept && in_last;

  // Tile-level FSM; ready is registered alongside the state so it never
  // depends combinationally on in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_last) begin
              if (ROWS > 1) begin
                state_q <= FLUSH;
                ready_q <= 1'b0;
                cnt_q   <= CW'(ROWS - 1);
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= STREAM;
            end
          end
        end
        FLUSH: begin
          // Counter reaches 0 on the same edge the FSM returns to IDLE,
          // giving exactly ROWS-1 flush cycles.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Row r is an (r+1)-deep register chain; stage 0 captures the accepted
  // element (or zeros on a bubble) and stage r drives the PE row.
  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_row
      logic [WIDTH-1:0] d_q [0:r];
      logic             v_q [0:r];
      logic             f_q [0:r];
      logic             l_q [0:r];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k <= r; k++) begin
            d_q[k] <= '0;
            v_q[k] <= 1'b0;
            f_q[k] <= 1'b0;
            l_q[k] <= 1'b0;
          end
        end else begin
          d_q[0] <= accept ? in_m[r*WIDTH +: WIDTH] : '0;
          v_q[0] <= accept;
          f_q[0] <= acc_first;
          l_q[0] <= acc_last;
          for (int k = 1; k <= r; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
            f_q[k] <= f_q[k-1];
            l_q[k] <= l_q[k-1];
          end
        end
      end

      assign o_m[r*WIDTH +: WIDTH] = d_q[r];
      assign o_valid[r]            = v_q[r];
      assign o_first[r]            = f_q[r];
      assign o_last[r]             = l_q[r];
    end
  endgenerate

  // o_done is loaded from the same source as the last row's final stage, so
  // it pulses coincident with o_last[ROWS-1].
  generate
    if (ROWS == 1) begin : g_done_one
      assign done_d = acc_last;
    end else begin : g_done_many
      assign done_d = g_row[ROWS-1].l_q[ROWS-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign o_done   = done_q;
  assign o_busy   = (state_q != IDLE);

endmodule
